// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter (double dabble) for the operator result display.
// One input bit per clock; magnitudes above 9999 saturate to 9999 and raise too_large.
module result_bcd_converter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             negative,
  output logic             too_large
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  localparam logic [4:0]       CntInit = 5'(WIDTH);
  localparam logic [WIDTH-1:0] OneW    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [19:0]      acc_q, acc_d;
  logic [19:0]      acc_adj;
  logic [4:0]       cnt_q, cnt_d;
  logic             neg_r_q, neg_r_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             negative_q, negative_d;
  logic             too_large_q, too_large_d;
  logic             done_q, done_d;
  logic             capture_neg;

  assign capture_neg = is_signed & value[WIDTH-1];

  // Add-3 correction so each digit carries correctly into the next on the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_r_d     = neg_r_q;
    bcd_d       = bcd_q;
    negative_d  = negative_q;
    too_large_d = too_large_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mag_d   = capture_neg ? (~value + OneW) : value;
          neg_r_d = capture_neg;
          acc_d   = 20'd0;
          cnt_d   = CntInit;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d          = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        if (acc_q[19:16] != 4'd0) begin
          bcd_d       = 16'h9999;
          too_large_d = 1'b1;
        end else begin
          bcd_d       = acc_q[15:0];
          too_large_d = 1'b0;
        end
        negative_d = neg_r_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mag_q       <= '0;
      acc_q       <= 20'd0;
      cnt_q       <= 5'd0;
      neg_r_q     <= 1'b0;
      bcd_q       <= 16'd0;
      negative_q  <= 1'b0;
      too_large_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_r_q     <= neg_r_d;
      bcd_q       <= bcd_d;
      negative_q  <= negative_d;
      too_large_q <= too_large_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign bcd       = bcd_q;
  assign negative  = negative_q;
  assign too_large = too_large_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: decimal reference model, monitor pops on done.
module tb_result_bcd_converter;

  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        tl;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        negative;
  logic        too_large;

  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t last_exp;

  result_bcd_converter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .negative  (negative),
    .too_large (too_large)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: decimal digits of the magnitude via plain arithmetic.
  function automatic exp_t model(input logic [15:0] v, input logic s);
    exp_t e;
    int   m;
    e.neg = s && v[15];
    m     = e.neg ? (65536 - int'(v)) : int'(v);
    e.tl  = (m > 9999);
    if (e.tl) m = 9999;
    e.bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          last_exp = sb_q.pop_front();
          check("bcd", {16'd0, bcd}, {16'd0, last_exp.bcd});
          check("negative", {31'd0, negative}, {31'd0, last_exp.neg});
          check("too_large", {31'd0, too_large}, {31'd0, last_exp.tl});
        end
      end else begin
        check("hold", {13'd0, too_large, negative, bcd}, {13'd0, last_exp.tl, last_exp.neg,
              last_exp.bcd});
      end
    end
  end

  // Launch one conversion; inject_at pulses a stray start, rst_at aborts via reset.
  task automatic convert(input logic [15:0] v, input logic s, input int inject_at,
                         input int rst_at);
    int k;
    int bc;
    @(negedge clk);
    if (busy) check("idle_before_start", {31'd0, busy}, 32'd0);
    start     = 1'b1;
    value     = v;
    is_signed = s;
    if (rst_at < 0) sb_q.push_back(model(v, s));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    k  = 0;
    bc = busy ? 1 : 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) bc++;
      if (k == inject_at) begin
        start = 1'b1;
        value = 16'h0005;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      if (k == rst_at) begin
        #2 rst = 1'b1;
        last_exp = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_outs", {13'd0, too_large, negative, bcd}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        return;
      end
    end
    check("latency", k, 32'd17);
    check("busy_cycles", bc, 32'd17);
  endtask

  initial begin
    int k;
    checks    = 0;
    errors    = 0;
    last_exp  = '0;
    rst       = 1'b1;
    start     = 1'b0;
    value     = 16'd0;
    is_signed = 1'b0;
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_outs", {13'd0, too_large, negative, bcd}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    convert(16'h04D2, 1'b0, -1, -1);
    convert(16'hFFFF, 1'b1, -1, -1);
    convert(16'hFFFF, 1'b0, -1, -1);
    convert(16'h8000, 1'b1, -1, -1);
    convert(16'h270F, 1'b0, -1, -1);
    convert(16'd1234, 1'b0, 5, -1);
    convert(16'h0000, 1'b1, -1, -1);
    convert(16'd1234, 1'b0, -1, 8);
    convert(16'h0063, 1'b0, -1, -1);

    // start held high: conversions every WIDTH+2 cycles.
    @(negedge clk);
    start     = 1'b1;
    value     = 16'd4321;
    is_signed = 1'b0;
    for (int n = 0; n < 3; n++) sb_q.push_back(model(16'd4321, 1'b0));
    for (int n = 0; n < 3; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 40);
      check("b2b_spacing", k, 32'd18);
    end
    start = 1'b0;

    for (int n = 0; n < 40; n++) begin
      convert(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), -1, -1);
    end
    convert(16'd9999, 1'b0, -1, -1);
    convert(16'd10000, 1'b0, -1, -1);
    convert(16'hD8F1, 1'b1, -1, -1);
    convert(16'hD8F0, 1'b1, -1, -1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
